// File: rtl/i2c_bus_cond_detector.sv
// ----------------------------------------------------------------------------
// i2c_bus_cond_detector
//
// Clocked bus-condition front end for the I2C EEPROM slave. Raw SCL/SDA from
// the pads are brought into the clk domain with a 2-FF synchroniser, then
// glitch-filtered. START, repeated START, STOP and SCL edges are reported as
// single-cycle registered pulses. The block also tracks whether the bus is
// busy and which bit of the 9-bit byte frame (8 data + ACK) is in progress.
//
// Optional feature macro: I2C_BUS_TIMEOUT_EN
//   When defined, a counter releases the bus (back to IDLE) after SCL has been
//   held low for TIMEOUT_CYC clk cycles while busy. When undefined, no counter
//   is built and timeout stays 0.
//
// Parameters
//   FILT_LEN     stable synchronised samples needed before a filtered line flips
//   TIMEOUT_CYC  SCL-low cycles while busy before a bus timeout
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   scl_in      raw SCL from the pad (asynchronous)
//   sda_in      raw SDA from the pad (asynchronous)
//   scl_f       synchronised + filtered SCL
//   sda_f       synchronised + filtered SDA
//   start_det   pulse on every START (including repeated START)
//   rstart_det  pulse on a START seen while the bus was already busy
//   stop_det    pulse on STOP
//   scl_rise    pulse on a rising edge of scl_f
//   scl_fall    pulse on a falling edge of scl_f
//   bus_busy    high between START and STOP (or timeout)
//   bit_idx     SCL rises since last START, 0..8
//   byte_done   pulse on the 9th (ACK) SCL rise of a frame
//   timeout     pulse on bus timeout
// ----------------------------------------------------------------------------
module i2c_bus_cond_detector #(
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_f,
  output logic       sda_f,
  output logic       start_det,
  output logic       rstart_det,
  output logic       stop_det,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       bus_busy,
  output logic [3:0] bit_idx,
  output logic       byte_done,
  output logic       timeout
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic           scl_s1, scl_s2, sda_s1, sda_s2;
  logic [FCW-1:0] scl_cnt, sda_cnt;
  logic           scl_d, sda_d;

  logic           scl_rise_c, scl_fall_c, start_c, stop_c;
  logic           to_hit;

  state_t         state_q, state_n;
  logic [3:0]     bit_idx_n;
  logic           start_n, rstart_n, stop_n, rise_n, fall_n;
  logic           byte_done_n, timeout_n;

  // Two-stage synchroniser per line. Reset to 1 so an idle bus is assumed
  // and no spurious edge is seen when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

  // SCL glitch filter: the filtered value only follows the synchronised line
  // after FILT_LEN consecutive disagreeing samples; any agreeing sample
  // restarts the count, so short spikes never reach scl_f.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_s2 == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == FILT_LAST) begin
      scl_f   <= ~scl_f;
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + 1'b1;
    end
  end

  // SDA glitch filter, identical in behaviour to the SCL one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_s2 == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == FILT_LAST) begin
      sda_f   <= ~sda_f;
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + 1'b1;
    end
  end

  // One-cycle delayed copies of the filtered lines for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // START/STOP need SCL high both before and after, so an SDA change in the
  // same cycle as an SCL change is reported only as an SCL edge.
  assign scl_rise_c = scl_f & ~scl_d;
  assign scl_fall_c = ~scl_f & scl_d;
  assign start_c    = scl_d & scl_f & sda_d & ~sda_f;
  assign stop_c     = scl_d & scl_f & ~sda_d & sda_f;

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC - 1);

  logic [TCW-1:0] to_cnt;

  // Counts clk cycles with SCL held low while the bus is busy. to_hit marks
  // the cycle in which the TIMEOUT_CYC-th low cycle is reached.
  assign to_hit = (state_q == BUSY) && !scl_f && (to_cnt == TO_LAST);

  // Stall counter: cleared whenever SCL is high, the bus is idle, or the
  // timeout has just fired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if ((state_q != BUSY) || scl_f || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State and registered outputs. Every detect output is a flop so the
  // slave FSM downstream sees clean, glitch-free single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_idx    <= 4'd0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      byte_done  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_idx    <= bit_idx_n;
      start_det  <= start_n;
      rstart_det <= rstart_n;
      stop_det   <= stop_n;
      scl_rise   <= rise_n;
      scl_fall   <= fall_n;
      byte_done  <= byte_done_n;
      timeout    <= timeout_n;
    end
  end

  // Next-state and next-output logic. START wins over everything (including
  // a coincident timeout) and restarts the frame; STOP and timeout both
  // release the bus. Only rises seen while busy advance the bit position,
  // and the 9th rise (ACK) closes the byte and wraps back to 0.
  always_comb begin
    state_n     = state_q;
    bit_idx_n   = bit_idx;
    start_n     = start_c;
    rstart_n    = start_c && (state_q == BUSY);
    stop_n      = stop_c;
    rise_n      = scl_rise_c;
    fall_n      = scl_fall_c;
    byte_done_n = 1'b0;
    timeout_n   = 1'b0;

    if (start_c) begin
      state_n   = BUSY;
      bit_idx_n = 4'd0;
    end else if (stop_c) begin
      state_n   = IDLE;
      bit_idx_n = 4'd0;
    end else if (to_hit) begin
      state_n   = IDLE;
      bit_idx_n = 4'd0;
      timeout_n = 1'b1;
    end else if (scl_rise_c && (state_q == BUSY)) begin
      if (bit_idx == 4'd8) begin
        bit_idx_n   = 4'd0;
        byte_done_n = 1'b1;
      end else begin
        bit_idx_n = bit_idx + 4'd1;
      end
    end
  end

  assign bus_busy = (state_q == BUSY);

endmodule

// File: tb/tb_i2c_bus_cond_detector.sv
// ----------------------------------------------------------------------------
// tb_i2c_bus_cond_detector
//
// Directed testbench for i2c_bus_cond_detector with FILT_LEN=3 and
// TIMEOUT_CYC=100. Inputs change 1 ns after a rising clock edge and outputs
// are sampled 1 ns after each rising edge, so a line change is seen as a
// pulse on the 6th sample after it is applied.
// ----------------------------------------------------------------------------
module tb_i2c_bus_cond_detector;

  logic       clk;
  logic       reset_n;
  logic       scl_in;
  logic       sda_in;
  logic       scl_f;
  logic       sda_f;
  logic       start_det;
  logic       rstart_det;
  logic       stop_det;
  logic       scl_rise;
  logic       scl_fall;
  logic       bus_busy;
  logic [3:0] bit_idx;
  logic       byte_done;
  logic       timeout;

  int nChecks = 0;
  int nFails  = 0;

  int nStart, nRstart, nStop, nRise, nFall, nByte, nTimeout, nSdaLow;

  i2c_bus_cond_detector #(
    .FILT_LEN   (3),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .start_det (start_det),
    .rstart_det(rstart_det),
    .stop_det  (stop_det),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .bus_busy  (bus_busy),
    .bit_idx   (bit_idx),
    .byte_done (byte_done),
    .timeout   (timeout)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value with its expected value and records it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Clears the pulse tallies before a new phase.
  task automatic clearCounts();
    nStart   = 0;
    nRstart  = 0;
    nStop    = 0;
    nRise    = 0;
    nFall    = 0;
    nByte    = 0;
    nTimeout = 0;
    nSdaLow  = 0;
  endtask

  // Advances n clock cycles, sampling 1 ns after each rising edge and
  // tallying every pulse seen.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (start_det)  nStart++;
      if (rstart_det) nRstart++;
      if (stop_det)   nStop++;
      if (scl_rise)   nRise++;
      if (scl_fall)   nFall++;
      if (byte_done)  nByte++;
      if (timeout)    nTimeout++;
      if (!sda_f)     nSdaLow++;
    end
  endtask

  // Drives both raw bus lines and holds them for the given number of cycles.
  task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
    scl_in = scl;
    sda_in = sda;
    tick(cycles);
  endtask

  initial begin
    reset_n = 1'b0;
    scl_in  = 1'b1;
    sda_in  = 1'b1;
    clearCounts();
    tick(3);

    $display("[TB] reset values");
    checkOutput("reset scl_f", scl_f, 1);
    checkOutput("reset sda_f", sda_f, 1);
    checkOutput("reset bus_busy", bus_busy, 0);
    checkOutput("reset bit_idx", bit_idx, 0);
    checkOutput("reset start_det", start_det, 0);
    checkOutput("reset timeout", timeout, 0);

    reset_n = 1'b1;
    tick(5);

    $display("[TB] SDA glitch shorter than filter");
    clearCounts();
    applyStimulus(1, 0, 2);
    applyStimulus(1, 1, 12);
    checkOutput("glitch sda_f low samples", nSdaLow, 0);
    checkOutput("glitch start count", nStart, 0);
    checkOutput("glitch stop count", nStop, 0);
    checkOutput("glitch bus_busy", bus_busy, 0);

    $display("[TB] START from idle");
    clearCounts();
    applyStimulus(1, 0, 5);
    checkOutput("start not early", start_det, 0);
    tick(1);
    checkOutput("start pulse at latency 6", start_det, 1);
    checkOutput("start rstart_det from idle", rstart_det, 0);
    checkOutput("start bus_busy", bus_busy, 1);
    checkOutput("start bit_idx", bit_idx, 0);
    tick(1);
    checkOutput("start pulse width", start_det, 0);
    tick(5);
    checkOutput("start count", nStart, 1);
    checkOutput("start sda_f", sda_f, 0);

    $display("[TB] nine SCL pulses");
    clearCounts();
    applyStimulus(0, 0, 8);
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) checkOutput("byte_done before 9th rise", nByte, 0);
      applyStimulus(1, 0, 8);
      checkOutput($sformatf("frame bit_idx after rise %0d", i), bit_idx, (i == 9) ? 0 : i);
      applyStimulus(0, 0, 8);
    end
    checkOutput("frame byte_done count", nByte, 1);
    checkOutput("frame rise count", nRise, 9);
    checkOutput("frame start count", nStart, 0);
    checkOutput("frame bus_busy", bus_busy, 1);

    $display("[TB] repeated START mid-byte");
    applyStimulus(0, 1, 8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 8);
      applyStimulus(0, 1, 8);
    end
    applyStimulus(1, 1, 8);
    checkOutput("rstart setup bit_idx", bit_idx, 4);
    clearCounts();
    applyStimulus(1, 0, 5);
    checkOutput("rstart not early", start_det, 0);
    tick(1);
    checkOutput("rstart start_det", start_det, 1);
    checkOutput("rstart rstart_det", rstart_det, 1);
    checkOutput("rstart bit_idx", bit_idx, 0);
    checkOutput("rstart bus_busy", bus_busy, 1);
    tick(6);
    checkOutput("rstart start count", nStart, 1);
    checkOutput("rstart rstart count", nRstart, 1);

    $display("[TB] STOP and simultaneous toggles");
    clearCounts();
    applyStimulus(1, 1, 5);
    checkOutput("stop not early", stop_det, 0);
    tick(1);
    checkOutput("stop stop_det", stop_det, 1);
    checkOutput("stop bus_busy", bus_busy, 0);
    checkOutput("stop bit_idx", bit_idx, 0);
    tick(6);
    checkOutput("stop count", nStop, 1);
    clearCounts();
    applyStimulus(0, 0, 12);
    checkOutput("both fall scl_fall count", nFall, 1);
    checkOutput("both fall start count", nStart, 0);
    checkOutput("both fall stop count", nStop, 0);
    applyStimulus(1, 1, 12);
    checkOutput("both rise scl_rise count", nRise, 1);
    checkOutput("both rise stop count", nStop, 0);
    checkOutput("both rise start count", nStart, 0);
    checkOutput("idle rise bit_idx", bit_idx, 0);
    checkOutput("idle rise bus_busy", bus_busy, 0);

    $display("[TB] SCL held low while busy");
    clearCounts();
    applyStimulus(1, 0, 10);
    checkOutput("stall start count", nStart, 1);
    applyStimulus(0, 0, 8);
    applyStimulus(1, 0, 8);
    checkOutput("stall setup bit_idx", bit_idx, 1);
    clearCounts();
    applyStimulus(0, 0, 150);
`ifdef I2C_BUS_TIMEOUT_EN
    checkOutput("stall timeout count", nTimeout, 1);
    checkOutput("stall bus_busy", bus_busy, 0);
    checkOutput("stall bit_idx", bit_idx, 0);
`else
    checkOutput("stall timeout count", nTimeout, 0);
    checkOutput("stall bus_busy", bus_busy, 1);
    checkOutput("stall bit_idx", bit_idx, 1);
`endif

    $display("[TB] reset mid-frame");
    clearCounts();
    applyStimulus(1, 0, 10);
    applyStimulus(1, 1, 10);
    checkOutput("prep stop count", nStop, 1);
    checkOutput("prep bus_busy after stop", bus_busy, 0);
    clearCounts();
    applyStimulus(1, 0, 10);
    checkOutput("prep start count", nStart, 1);
    applyStimulus(0, 0, 8);
    applyStimulus(1, 0, 8);
    applyStimulus(0, 0, 3);
    checkOutput("prep bit_idx", bit_idx, 1);
    checkOutput("prep bus_busy", bus_busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset bus_busy", bus_busy, 0);
    checkOutput("async reset bit_idx", bit_idx, 0);
    checkOutput("async reset scl_f", scl_f, 1);
    checkOutput("async reset sda_f", sda_f, 1);
    checkOutput("async reset scl_fall", scl_fall, 0);
    checkOutput("async reset byte_done", byte_done, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
